// File: rtl/rob_pkg.sv
// Shared widths and the reorder-buffer entry record used by the ROB and its commit scan.
package rob_pkg;

  localparam int ARF_W = 5;
  localparam int PRF_W = 6;
  localparam int PC_W  = 64;

  typedef struct packed {
    logic             valid;
    logic             done;
    logic [ARF_W-1:0] arf;
    logic [PRF_W-1:0] prf;
    logic             is_branch;
    logic             is_store;
    logic             mispredict;
    logic [PC_W-1:0]  npc;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit_select.sv
// In-order retirement scan over the COMMIT_W oldest entries; stops at the first
// not-ready entry and after the first mispredicted branch.
module rob_commit_select #(
  parameter int COMMIT_W = 2,
  parameter int NC_W     = $clog2(COMMIT_W + 1)
) (
  input  logic [COMMIT_W-1:0] slot_ready_in,
  input  logic [COMMIT_W-1:0] slot_mispredict_in,
  output logic [COMMIT_W-1:0] slot_valid_out,
  output logic [NC_W-1:0]     n_commit_out
);

  always_comb begin
    logic chain_open;
    chain_open     = 1'b1;
    slot_valid_out = '0;
    n_commit_out   = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      slot_valid_out[k] = chain_open & slot_ready_in[k];
      if (slot_valid_out[k]) begin
        n_commit_out = NC_W'(k + 1);
      end
      chain_open = slot_valid_out[k] & ~slot_mispredict_in[k];
    end
  end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer: one in-order dispatch per cycle, CDB/ex completion, up to COMMIT_W
// in-order retirements per cycle, full flush when a mispredicted branch retires.
module rob_multi_commit
  import rob_pkg::*;
#(
  parameter int ROB_SIZE  = 32,
  parameter int CDB_PORTS = 2,
  parameter int COMMIT_W  = 2,
  localparam int IDX_W    = $clog2(ROB_SIZE),
  localparam int CNT_W    = IDX_W + 1,
  localparam int NC_W     = $clog2(COMMIT_W + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          id_valid_inst_in,
  input  logic [ARF_W-1:0]              id_ARF_num_in,
  input  logic [PRF_W-1:0]              id_PRF_num_in,
  input  logic                          id_is_branch_in,
  input  logic                          id_is_store_in,
  input  logic [CDB_PORTS-1:0]          CDB_valid_in,
  input  logic [CDB_PORTS*PRF_W-1:0]    CDB_tag_in,
  input  logic                          ex_valid_in,
  input  logic [IDX_W-1:0]              ex_ROB_num_in,
  input  logic                          ex_mispredict_in,
  input  logic [PC_W-1:0]               ex_NPC_in,
  output logic [COMMIT_W-1:0]           commit_valid_out,
  output logic [COMMIT_W*ARF_W-1:0]     commit_ARF_num_out,
  output logic [COMMIT_W*PRF_W-1:0]     commit_PRF_num_out,
  output logic [COMMIT_W-1:0]           commit_is_store_out,
  output logic [COMMIT_W-1:0]           commit_is_branch_out,
  output logic                          ROB_squash_out,
  output logic [PC_W-1:0]               ROB_NPC_out,
  output logic [IDX_W-1:0]              ROB_alloc_num_out,
  output logic                          ROB_dispatch_disable,
  output logic [CNT_W-1:0]              ROB_count_out,
  output logic [IDX_W-1:0]              ROB_head,
  output logic [IDX_W-1:0]              ROB_tail
);

  rob_entry_t entry_q [ROB_SIZE];
  rob_entry_t entry_d [ROB_SIZE];
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  rob_entry_t [COMMIT_W-1:0] slot_entry;
  logic [COMMIT_W-1:0] slot_ready, slot_misp, slot_valid, slot_squash;
  logic [NC_W-1:0]     n_commit;
  logic                squash;
  logic                accept;

  for (genvar gi = 0; gi < COMMIT_W; gi++) begin : g_slot
    logic [IDX_W-1:0] idx;
    assign idx              = head_q + IDX_W'(gi);
    assign slot_entry[gi]   = entry_q[idx];
    assign slot_ready[gi]   = slot_entry[gi].valid & slot_entry[gi].done;
    assign slot_misp[gi]    = slot_entry[gi].mispredict;
    assign slot_squash[gi]  = slot_valid[gi] & slot_entry[gi].mispredict;

    assign commit_valid_out[gi]               = slot_valid[gi];
    assign commit_ARF_num_out[gi*ARF_W +: ARF_W] = slot_valid[gi] ? slot_entry[gi].arf : '0;
    assign commit_PRF_num_out[gi*PRF_W +: PRF_W] = slot_valid[gi] ? slot_entry[gi].prf : '0;
    assign commit_is_store_out[gi]            = slot_valid[gi] & slot_entry[gi].is_store;
    assign commit_is_branch_out[gi]           = slot_valid[gi] & slot_entry[gi].is_branch;
  end

  rob_commit_select #(
    .COMMIT_W (COMMIT_W),
    .NC_W     (NC_W)
  ) u_commit_select (
    .slot_ready_in      (slot_ready),
    .slot_mispredict_in (slot_misp),
    .slot_valid_out     (slot_valid),
    .n_commit_out       (n_commit)
  );

  assign squash = |slot_squash;

  // At most one slot can squash, so an OR-merge of the masked NPCs is exact.
  always_comb begin
    ROB_NPC_out = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (slot_squash[k]) begin
        ROB_NPC_out = ROB_NPC_out | slot_entry[k].npc;
      end
    end
  end

  assign accept = id_valid_inst_in && !squash &&
                  ((count_q < CNT_W'(ROB_SIZE)) || (n_commit != '0));

  always_comb begin
    for (int i = 0; i < ROB_SIZE; i++) begin
      logic             cdb_hit;
      logic [IDX_W-1:0] offset;
      entry_d[i] = entry_q[i];
      cdb_hit    = 1'b0;
      for (int p = 0; p < CDB_PORTS; p++) begin
        if (CDB_valid_in[p] && (CDB_tag_in[p*PRF_W +: PRF_W] == entry_q[i].prf)) begin
          cdb_hit = 1'b1;
        end
      end
      if (entry_q[i].valid && !entry_q[i].done && (entry_q[i].prf != '0) && cdb_hit) begin
        entry_d[i].done = 1'b1;
      end
      if (ex_valid_in && (ex_ROB_num_in == IDX_W'(i)) && entry_q[i].valid) begin
        entry_d[i].done       = 1'b1;
        entry_d[i].mispredict = ex_mispredict_in;
        entry_d[i].npc        = ex_NPC_in;
      end
      // Retired entries are wiped so their done/mispredict bits cannot leak into reuse.
      offset = IDX_W'(i) - head_q;
      if (int'(offset) < int'(n_commit)) begin
        entry_d[i] = '0;
      end
    end

    if (accept) begin
      entry_d[tail_q]           = '0;
      entry_d[tail_q].valid     = 1'b1;
      entry_d[tail_q].arf       = id_ARF_num_in;
      entry_d[tail_q].prf       = id_PRF_num_in;
      entry_d[tail_q].is_branch = id_is_branch_in;
      entry_d[tail_q].is_store  = id_is_store_in;
    end

    if (squash) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entry_d[i] = '0;
      end
    end
  end

  always_comb begin
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + IDX_W'(n_commit);
      tail_d  = tail_q + IDX_W'(accept);
      count_d = count_q + CNT_W'(accept) - CNT_W'(n_commit);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < ROB_SIZE; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  assign ROB_squash_out       = squash;
  assign ROB_alloc_num_out    = tail_q;
  assign ROB_dispatch_disable = (count_q == CNT_W'(ROB_SIZE));
  assign ROB_count_out        = count_q;
  assign ROB_head             = head_q;
  assign ROB_tail             = tail_q;

endmodule

// File: tb/tb_rob_multi_commit.sv
// Bench for rob_multi_commit: vector table plus directed sequences, with a commit-order scoreboard.
module tb_rob_multi_commit;

  logic        clock;
  logic        reset;
  logic        id_valid_inst_in;
  logic [4:0]  id_ARF_num_in;
  logic [5:0]  id_PRF_num_in;
  logic        id_is_branch_in;
  logic        id_is_store_in;
  logic [1:0]  CDB_valid_in;
  logic [11:0] CDB_tag_in;
  logic        ex_valid_in;
  logic [4:0]  ex_ROB_num_in;
  logic        ex_mispredict_in;
  logic [63:0] ex_NPC_in;
  logic [1:0]  commit_valid_out;
  logic [9:0]  commit_ARF_num_out;
  logic [11:0] commit_PRF_num_out;
  logic [1:0]  commit_is_store_out;
  logic [1:0]  commit_is_branch_out;
  logic        ROB_squash_out;
  logic [63:0] ROB_NPC_out;
  logic [4:0]  ROB_alloc_num_out;
  logic        ROB_dispatch_disable;
  logic [5:0]  ROB_count_out;
  logic [4:0]  ROB_head;
  logic [4:0]  ROB_tail;

  rob_multi_commit dut (
    .clock                (clock),
    .reset                (reset),
    .id_valid_inst_in     (id_valid_inst_in),
    .id_ARF_num_in        (id_ARF_num_in),
    .id_PRF_num_in        (id_PRF_num_in),
    .id_is_branch_in      (id_is_branch_in),
    .id_is_store_in       (id_is_store_in),
    .CDB_valid_in         (CDB_valid_in),
    .CDB_tag_in           (CDB_tag_in),
    .ex_valid_in          (ex_valid_in),
    .ex_ROB_num_in        (ex_ROB_num_in),
    .ex_mispredict_in     (ex_mispredict_in),
    .ex_NPC_in            (ex_NPC_in),
    .commit_valid_out     (commit_valid_out),
    .commit_ARF_num_out   (commit_ARF_num_out),
    .commit_PRF_num_out   (commit_PRF_num_out),
    .commit_is_store_out  (commit_is_store_out),
    .commit_is_branch_out (commit_is_branch_out),
    .ROB_squash_out       (ROB_squash_out),
    .ROB_NPC_out          (ROB_NPC_out),
    .ROB_alloc_num_out    (ROB_alloc_num_out),
    .ROB_dispatch_disable (ROB_dispatch_disable),
    .ROB_count_out        (ROB_count_out),
    .ROB_head             (ROB_head),
    .ROB_tail             (ROB_tail)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       disp;
    logic [5:0] prf;
    logic [1:0] cdb_v;
    logic [5:0] t0;
    logic [5:0] t1;
    logic [1:0] exp_cv;
    int         exp_cnt;
  } vec_t;

  vec_t        tbl [14];
  logic [13:0] sb [$];
  int          checks;
  int          errors;
  int          exp_count, exp_head, exp_tail;
  logic [1:0]  last_cv, last_isbr;
  logic [11:0] last_prf;
  logic        last_sq;
  logic [63:0] last_npc;
  int          last_cnt;
  int          idx_of [64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    id_valid_inst_in = 1'b0;
    id_ARF_num_in    = '0;
    id_PRF_num_in    = '0;
    id_is_branch_in  = 1'b0;
    id_is_store_in   = 1'b0;
    CDB_valid_in     = '0;
    CDB_tag_in       = '0;
    ex_valid_in      = 1'b0;
    ex_ROB_num_in    = '0;
    ex_mispredict_in = 1'b0;
    ex_NPC_in        = '0;
  endtask

  task automatic disp(input logic [4:0] a, input logic [5:0] p, input logic st, input logic br);
    id_valid_inst_in = 1'b1;
    id_ARF_num_in    = a;
    id_PRF_num_in    = p;
    id_is_store_in   = st;
    id_is_branch_in  = br;
  endtask

  task automatic cdb(input int port, input logic [5:0] tag);
    CDB_valid_in[port] = 1'b1;
    CDB_tag_in[port*6 +: 6] = tag;
  endtask

  task automatic ex(input logic [4:0] idx, input logic misp, input logic [63:0] npc);
    ex_valid_in      = 1'b1;
    ex_ROB_num_in    = idx;
    ex_mispredict_in = misp;
    ex_NPC_in        = npc;
  endtask

  // One clock: check state against the model, retire into the scoreboard, then advance.
  task automatic cycle();
    int         nc;
    logic       acc;
    logic [13:0] got;
    @(negedge clock);
    chk("count", ROB_count_out, exp_count);
    chk("head", ROB_head, exp_head);
    chk("tail", ROB_tail, exp_tail);
    chk("alloc", ROB_alloc_num_out, exp_tail);
    chk("disable", ROB_dispatch_disable, exp_count == 32);
    nc = 0;
    for (int k = 0; k < 2; k++) begin
      got = {commit_ARF_num_out[k*5 +: 5], commit_PRF_num_out[k*6 +: 6],
             commit_is_store_out[k], commit_is_branch_out[k], 1'b1};
      if (commit_valid_out[k]) begin
        nc++;
        if (sb.size() == 0) begin
          chk("commit_unexpected", got, 14'h0);
        end else begin
          chk("commit_entry", got, sb.pop_front());
        end
      end else begin
        chk("idle_slot", got, 14'h1);
      end
    end
    last_cv   = commit_valid_out;
    last_isbr = commit_is_branch_out;
    last_prf  = commit_PRF_num_out;
    last_sq   = ROB_squash_out;
    last_npc  = ROB_NPC_out;
    last_cnt  = ROB_count_out;
    acc = id_valid_inst_in && !ROB_squash_out && (exp_count < 32 || nc > 0);
    if (ROB_squash_out) begin
      sb.delete();
      exp_count = 0;
      exp_head  = 0;
      exp_tail  = 0;
    end else begin
      if (acc) sb.push_back({id_ARF_num_in, id_PRF_num_in, id_is_store_in, id_is_branch_in, 1'b1});
      exp_head  = (exp_head + nc) % 32;
      exp_tail  = (exp_tail + (acc ? 1 : 0)) % 32;
      exp_count = exp_count + (acc ? 1 : 0) - nc;
    end
    @(posedge clock);
    #1;
    clear_inputs();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && ROB_count_out != 0; i++) cycle();
    chk(name, ROB_count_out, 0);
  endtask

  task automatic rst_checks(input string name);
    chk({name, "_commit"}, {commit_valid_out, commit_ARF_num_out, commit_PRF_num_out,
                           commit_is_store_out, commit_is_branch_out}, 0);
    chk({name, "_npc"}, ROB_NPC_out, 0);
    chk({name, "_state"}, {ROB_squash_out, ROB_alloc_num_out, ROB_dispatch_disable,
                          ROB_count_out, ROB_head, ROB_tail}, 0);
  endtask

  initial begin
    int br_idx, t;
    checks = 0; errors = 0;
    exp_count = 0; exp_head = 0; exp_tail = 0;
    //          disp prf   cdb_v  t0  t1  cv     cnt
    tbl[0]  = '{1, 6'd10, 2'b00,  0,  0, 2'b00, 0};
    tbl[1]  = '{1, 6'd11, 2'b01, 10,  0, 2'b00, 1};
    tbl[2]  = '{1, 6'd12, 2'b10,  0, 11, 2'b01, 2};
    tbl[3]  = '{0, 6'd0,  2'b01, 12,  0, 2'b01, 2};
    tbl[4]  = '{0, 6'd0,  2'b00,  0,  0, 2'b01, 1};
    tbl[5]  = '{1, 6'd20, 2'b00,  0,  0, 2'b00, 0};
    tbl[6]  = '{1, 6'd21, 2'b01, 21,  0, 2'b00, 1};
    tbl[7]  = '{1, 6'd22, 2'b10,  0, 22, 2'b00, 2};
    tbl[8]  = '{0, 6'd0,  2'b01, 22,  0, 2'b00, 3};
    tbl[9]  = '{0, 6'd0,  2'b00,  0,  0, 2'b00, 3};
    tbl[10] = '{0, 6'd0,  2'b01, 20,  0, 2'b00, 3};
    tbl[11] = '{0, 6'd0,  2'b01, 21,  0, 2'b01, 3};
    tbl[12] = '{0, 6'd0,  2'b00,  0,  0, 2'b11, 2};
    tbl[13] = '{0, 6'd0,  2'b00,  0,  0, 2'b00, 0};

    reset = 1'b0;
    clear_inputs();
    #1;
    rst_checks("reset");
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;

    // Vector table: completions, same-cycle-dispatch blindness, in-order stall.
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].disp) disp(5'(i), tbl[i].prf, 1'b0, 1'b0);
      if (tbl[i].cdb_v[0]) cdb(0, tbl[i].t0);
      if (tbl[i].cdb_v[1]) cdb(1, tbl[i].t1);
      cycle();
      chk($sformatf("tbl%0d_cv", i), last_cv, tbl[i].exp_cv);
      chk($sformatf("tbl%0d_cnt", i), last_cnt, tbl[i].exp_cnt);
    end
    $display("table done: head=%0d tail=%0d", ROB_head, ROB_tail);

    // Fill to full, blocked dispatch, then commit-and-dispatch in the same cycle.
    for (int i = 1; i <= 32; i++) begin
      disp(5'(i), 6'(i), 1'b0, 1'b0);
      cycle();
    end
    chk("full_disable", ROB_dispatch_disable, 1);
    chk("full_count", ROB_count_out, 32);
    disp(5'd8, 6'd40, 1'b0, 1'b0);
    cycle();
    chk("full_blocked_cnt", ROB_count_out, 32);
    cdb(0, 6'd1);
    cycle();
    disp(5'd9, 6'd41, 1'b0, 1'b0);
    cycle();
    chk("swap_cv", last_cv, 2'b01);
    chk("swap_count", ROB_count_out, 32);
    $display("full test done: count=%0d", ROB_count_out);

    // Dual commit from two CDB ports.
    cdb(0, 6'd2); cdb(1, 6'd3);
    cycle();
    cycle();
    chk("dual_cv", last_cv, 2'b11);
    chk("dual_prf", last_prf, {6'd3, 6'd2});
    chk("dual_head", ROB_head, 9);
    for (int tg = 4; tg <= 32; tg += 2) begin
      cdb(0, 6'(tg));
      if (tg + 1 <= 32) cdb(1, 6'(tg + 1));
      cycle();
    end
    cdb(0, 6'd41);
    cycle();
    drain("drain_full");
    $display("dual commit done: head=%0d", ROB_head);

    // Mispredicted branch behind two ready entries.
    disp(5'd3, 6'd50, 1'b0, 1'b0); cycle();
    disp(5'd4, 6'd51, 1'b0, 1'b0); cycle();
    br_idx = exp_tail;
    disp(5'd0, 6'd0, 1'b0, 1'b1); cycle();
    disp(5'd5, 6'd52, 1'b0, 1'b0);
    cdb(0, 6'd50); cdb(1, 6'd51);
    ex(5'(br_idx), 1'b1, 64'd200);
    cycle();
    cycle();
    chk("pre_squash_cv", last_cv, 2'b11);
    chk("pre_squash_sq", last_sq, 0);
    disp(5'd6, 6'd53, 1'b0, 1'b0);
    cycle();
    chk("squash_sq", last_sq, 1);
    chk("squash_npc", last_npc, 64'd200);
    chk("squash_cv", last_cv, 2'b01);
    chk("squash_isbr", last_isbr, 2'b01);
    chk("post_squash", {ROB_head, ROB_tail, ROB_count_out}, 0);
    $display("squash done: head=%0d tail=%0d count=%0d", ROB_head, ROB_tail, ROB_count_out);

    // Asynchronous reset in the middle of a cycle with 7 entries live.
    for (int i = 1; i <= 7; i++) begin
      disp(5'(i), 6'(i), 1'b0, 1'b0);
      cycle();
    end
    cdb(0, 6'd1);
    cycle();
    chk("prerst_count", ROB_count_out, 7);
    chk("prerst_cv", commit_valid_out, 2'b01);
    #2 reset = 1'b0;
    #1;
    rst_checks("midrst");
    sb.delete();
    exp_count = 0; exp_head = 0; exp_tail = 0;
    @(posedge clock); #1;
    reset = 1'b1;
    $display("mid-run reset done");

    // Wrap: stores resolved by ex while dispatching; tail wraps 31->0.
    for (int i = 0; i < 16; i++) begin
      idx_of[i] = exp_tail;
      disp(5'(i), 6'd0, 1'b1, 1'b0);
      cycle();
    end
    for (int i = 0; i < 32; i++) begin
      idx_of[16 + i] = exp_tail;
      disp(5'(16 + i), 6'd0, 1'b1, 1'b0);
      ex(5'(idx_of[i]), 1'b0, 64'd0);
      cycle();
    end
    cycle(); cycle(); cycle();
    chk("wrap_tail", ROB_tail, 16);
    chk("wrap_head", ROB_head, 0);
    chk("wrap_count", ROB_count_out, 16);
    chk("stale_cv", commit_valid_out, 2'b00);
    for (int i = 32; i < 48; i++) begin
      ex(5'(idx_of[i]), 1'b0, 64'd0);
      cycle();
    end
    drain("drain_wrap");
    chk("wrap_ptrs", {ROB_head, ROB_tail}, {5'd16, 5'd16});

    // ex on an empty slot must not pre-complete the entry dispatched there later.
    t = exp_tail;
    ex(5'(t), 1'b0, 64'd0);
    cycle();
    disp(5'd9, 6'd0, 1'b1, 1'b0);
    cycle();
    cycle(); cycle();
    chk("ghost_ex_cv", last_cv, 2'b00);
    chk("ghost_ex_cnt", ROB_count_out, 1);
    ex(5'(t), 1'b0, 64'd0);
    cycle();
    drain("drain_ghost");
    chk("sb_empty", sb.size(), 0);
    $display("wrap test done: head=%0d tail=%0d", ROB_head, ROB_tail);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
